// File: rtl/tsv_shift_tx.sv
// TSV transmitter with shift-based spare repair: a scan maps DATA_W logical bits onto
// DATA_W+2 physical TSVs around faulty ones, then drives data through that mapping.
module tsv_shift_tx #(
    parameter int DATA_W = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic [DATA_W+1:0]     fault_map,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     data_in,
    output logic [DATA_W+1:0]     tsv_out,
    output logic                  tsv_valid,
    output logic [3*DATA_W-1:0]   ctrl_flags,
    output logic                  cfg_done,
    output logic                  cfg_fail
);

    localparam int TSV_W = DATA_W + 2;
    localparam int IDX_W = $clog2(TSV_W);
    localparam int B_W   = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, SCAN, RUN, FAIL} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   done_nxt;
    logic                   load_cfg;
    logic                   bits_left;
    logic                   last_idx;
    logic                   accept;

    logic [TSV_W-1:0]       fmap;
    logic [IDX_W-1:0]       idx;
    logic [B_W-1:0]         b;
    logic [1:0]             s;
    logic [2*DATA_W-1:0]    shift_q;

    logic                   done_p1;
    logic [TSV_W-1:0]       tsv_word_p1;
    logic                   vld_p1;

    // Place each logical bit on TSV i+s_i; TSVs carrying no bit are driven 0.
    function automatic logic [TSV_W-1:0] map_word(input logic [DATA_W-1:0]   d,
                                                  input logic [2*DATA_W-1:0] sh);
        logic [TSV_W-1:0] w;
        w = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w[i + int'(sh[2*i +: 2])] = d[i];
        end
        return w;
    endfunction

    assign load_cfg  = cfg_start && (state != SCAN);
    assign bits_left = (b < B_W'(DATA_W));
    assign last_idx  = (idx == IDX_W'(TSV_W - 1));
    assign accept    = in_valid && (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE, RUN, FAIL: begin
                if (cfg_start) state_nxt = SCAN;
            end
            SCAN: begin
                // A third counted fault would need shift 3, which the 3-input mux cannot select.
                if (fmap[idx] && bits_left && (s == 2'd2)) begin
                    state_nxt = FAIL;
                end else if (last_idx) begin
                    state_nxt = RUN;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fmap    <= '0;
            idx     <= '0;
            b       <= '0;
            s       <= '0;
            shift_q <= '0;
        end else if (load_cfg) begin
            fmap    <= fault_map;
            idx     <= '0;
            b       <= '0;
            s       <= '0;
            shift_q <= '0;
        end else if (state == SCAN) begin
            idx <= idx + IDX_W'(1);
            if (bits_left) begin
                if (fmap[idx]) begin
                    s <= s + 2'd1;
                end else begin
                    shift_q[2*b +: 2] <= s;
                    b                 <= b + B_W'(1);
                end
            end
        end
    end

    // Stage p1: registered TSV drive, valid flag and scan-done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tsv_word_p1 <= '0;
            vld_p1      <= 1'b0;
            done_p1     <= 1'b0;
        end else begin
            vld_p1  <= accept;
            done_p1 <= done_nxt;
            if (accept) tsv_word_p1 <= map_word(data_in, shift_q);
        end
    end

    always_comb begin
        ctrl_flags = '0;
        if (state == RUN) begin
            for (int i = 0; i < DATA_W; i++) begin
                ctrl_flags[3*i +: 3] = 3'b001 << shift_q[2*i +: 2];
            end
        end
    end

    assign in_ready  = (state == RUN);
    assign cfg_fail  = (state == FAIL);
    assign cfg_done  = done_p1;
    assign tsv_out   = tsv_word_p1;
    assign tsv_valid = vld_p1;

endmodule

// File: tb/tb_tsv_shift_tx.sv
// Randomised and directed bench for tsv_shift_tx against a greedy-mapping reference model.
module tb_tsv_shift_tx;

    localparam int DATA_W = 7;
    localparam int TSV_W  = DATA_W + 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                cfg_start = 1'b0;
    logic [TSV_W-1:0]    fault_map = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [DATA_W-1:0]   data_in = '0;
    logic [TSV_W-1:0]    tsv_out;
    logic                tsv_valid;
    logic [3*DATA_W-1:0] ctrl_flags;
    logic                cfg_done;
    logic                cfg_fail;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode 0 idle, 1 scanning, 2 running, 3 failed.
    int               m_mode = 0;
    int               m_cnt = 0;
    bit               m_fail_scan = 1'b0;
    int               m_pos [DATA_W];
    logic [TSV_W-1:0] m_tsv = '0;
    logic             m_tvld = 1'b0;
    logic             m_done = 1'b0;

    tsv_shift_tx #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_start  (cfg_start),
        .fault_map  (fault_map),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .tsv_out    (tsv_out),
        .tsv_valid  (tsv_valid),
        .ctrl_flags (ctrl_flags),
        .cfg_done   (cfg_done),
        .cfg_fail   (cfg_fail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Healthy TSVs are handed to bits in order; a scan dies on the third fault seen
    // before every bit has a home, at the cycle that examines that TSV.
    task automatic plan(input logic [TSV_W-1:0] fm);
        int nb, nf;
        nb = 0;
        nf = 0;
        m_fail_scan = 1'b0;
        m_cnt = TSV_W;
        for (int i = 0; i < DATA_W; i++) m_pos[i] = i;
        for (int j = 0; j < TSV_W; j++) begin
            if (nb < DATA_W && !m_fail_scan) begin
                if (fm[j]) begin
                    nf++;
                    if (nf == 3) begin
                        m_fail_scan = 1'b1;
                        m_cnt = j + 1;
                    end
                end else begin
                    m_pos[nb] = j;
                    nb++;
                end
            end
        end
    endtask

    task automatic model_update();
        m_tvld = 1'b0;
        m_done = 1'b0;
        if (m_mode == 2 && in_valid) begin
            m_tsv = '0;
            for (int i = 0; i < DATA_W; i++) m_tsv[m_pos[i]] = data_in[i];
            m_tvld = 1'b1;
        end
        if (m_mode == 1) begin
            m_cnt--;
            if (m_cnt == 0) begin
                if (m_fail_scan) m_mode = 3;
                else begin
                    m_mode = 2;
                    m_done = 1'b1;
                end
            end
        end else if (cfg_start) begin
            plan(fault_map);
            m_mode = 1;
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_cnt  = 0;
        m_tsv  = '0;
        m_tvld = 1'b0;
        m_done = 1'b0;
    endtask

    task automatic compare();
        logic [3*DATA_W-1:0] ec;
        ec = '0;
        if (m_mode == 2)
            for (int i = 0; i < DATA_W; i++) ec[3*i +: 3] = 3'b001 << (m_pos[i] - i);
        chk("in_ready",   in_ready,   m_mode == 2);
        chk("cfg_fail",   cfg_fail,   m_mode == 3);
        chk("cfg_done",   cfg_done,   m_done);
        chk("tsv_valid",  tsv_valid,  m_tvld);
        chk("tsv_out",    tsv_out,    m_tsv);
        chk("ctrl_flags", ctrl_flags, ec);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare();
    endtask

    task automatic start_cfg(input logic [TSV_W-1:0] fm);
        fault_map = fm;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        data_in  = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_tsv"},   tsv_out,    '0);
        chk({nm, "_vld"},   tsv_valid,  '0);
        chk({nm, "_rdy"},   in_ready,   '0);
        chk({nm, "_ctrl"},  ctrl_flags, '0);
        chk({nm, "_done"},  cfg_done,   '0);
        chk({nm, "_fail"},  cfg_fail,   '0);
    endtask

    initial begin
        for (int i = 0; i < DATA_W; i++) m_pos[i] = i;
        #2;
        check_all_zero("reset");
        #20;
        rst_n = 1'b1;

        // Data ignored before any configuration.
        send(7'h2A);
        chk("pre_cfg_tsv", tsv_out, '0);

        // Fault-free map.
        start_cfg('0);
        repeat (8) step();
        chk("031_not_yet", cfg_done, 1'b0);
        step();
        chk("031_done", cfg_done, 1'b1);
        chk("031_ctrl", ctrl_flags, {7{3'b001}});
        send(7'h55);
        chk("031_tsv", tsv_out, 9'h055);
        chk("031_vld", tsv_valid, 1'b1);

        // TSV3 faulty.
        start_cfg(9'h008);
        repeat (9) step();
        chk("032_ctrl", ctrl_flags, {{4{3'b010}}, {3{3'b001}}});
        send(7'h7F);
        chk("032_tsv", tsv_out, 9'h0F7);

        // Idle in RUN: output must hold.
        repeat (5) begin
            step();
            chk("035_hold_tsv", tsv_out, 9'h0F7);
            chk("035_hold_vld", tsv_valid, 1'b0);
        end

        // TSV0 and TSV8 faulty; TSV8 ignored.
        start_cfg(9'h101);
        chk("026_hold", tsv_out, 9'h0F7);
        repeat (9) step();
        chk("033_rdy", in_ready, 1'b1);
        chk("033_ctrl", ctrl_flags, {7{3'b010}});
        send(7'h01);
        chk("033_tsv", tsv_out, 9'h002);

        // Unrepairable map, then recovery.
        start_cfg(9'h007);
        step();
        step();
        chk("034_not_yet", cfg_fail, 1'b0);
        step();
        chk("034_fail", cfg_fail, 1'b1);
        chk("034_rdy", in_ready, 1'b0);
        chk("034_ctrl", ctrl_flags, '0);
        repeat (10) step();
        send(7'h11);
        chk("034_no_accept", tsv_out, 9'h002);
        start_cfg('0);
        chk("034_cleared", cfg_fail, 1'b0);
        repeat (9) step();
        chk("034_run", in_ready, 1'b1);

        // cfg_start mid-scan is ignored.
        start_cfg('0);
        repeat (3) step();
        fault_map = 9'h1FF;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        repeat (4) step();
        chk("035_scan_len", in_ready, 1'b0);
        step();
        chk("035_done", cfg_done, 1'b1);
        chk("035_ctrl", ctrl_flags, {7{3'b001}});

        // Asynchronous reset mid-scan.
        send(7'h7F);
        start_cfg(9'h010);
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        check_all_zero("036");
        model_reset();
        #10;
        rst_n = 1'b1;
        send(7'h7F);
        chk("036_rdy", in_ready, 1'b0);
        chk("036_tsv", tsv_out, '0);

        // Randomised traffic and reconfiguration.
        for (int c = 0; c < 4000; c++) begin
            cfg_start = ($urandom_range(0, 39) == 0);
            fault_map = '0;
            for (int k = 0; k < int'($urandom_range(0, 3)); k++)
                fault_map[$urandom_range(0, TSV_W - 1)] = 1'b1;
            in_valid = ($urandom_range(0, 3) != 0);
            data_in  = DATA_W'($urandom);
            step();
        end
        cfg_start = 1'b0;
        in_valid  = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tsv_shift_tx.md
TSV_SHIFT_TX -- requirements
Module: tsv_shift_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 7, meaning the number of logical data bits carried per transfer.
REQ-002 SHALL derive TSV_W = DATA_W+2 (two spare TSVs); TSV_W is not a port-level parameter.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 cfg_start  input  1  single-cycle pulse that loads fault_map and starts a repair scan.
REQ-006 fault_map  input  TSV_W  bit j=1 marks physical TSV j faulty; sampled only on an accepted cfg_start.
REQ-007 in_valid  input  1  data_in is valid this cycle.
REQ-008 in_ready  output  1  block accepts data_in this cycle.
REQ-009 data_in  input  DATA_W  logical data word.
REQ-010 tsv_out  output  TSV_W  registered drive onto the physical TSVs.
REQ-011 tsv_valid  output  1  tsv_out was updated with a new word this cycle.
REQ-012 ctrl_flags  output  3*DATA_W  per-bit one-hot shift select for the receiving 3-input TSV mux; field i is [3i+2:3i], and flag k means bit i travels on TSV i+k.
REQ-013 cfg_done  output  1  single-cycle pulse when a scan completes successfully.
REQ-014 cfg_fail  output  1  level; repair is impossible with the current fault map.

Function
REQ-015 SHALL implement the FSM states IDLE, SCAN, RUN and FAIL.
REQ-016 cfg_start in IDLE, RUN or FAIL SHALL latch fault_map, clear the scan state (idx=0, bit index b=0, shift s=0, all stored shifts=0) and enter SCAN; cfg_start during SCAN SHALL be ignored.
REQ-017 SCAN SHALL process one TSV per cycle, idx = 0..TSV_W-1.
  - If TSV idx is faulty and b<DATA_W: s increments.
  - Else if TSV idx is healthy and b<DATA_W: bit b is stored with shift s, and b increments.
  - If b==DATA_W: the TSV is ignored.
REQ-018 If s would reach 3, the block SHALL enter FAIL in the next cycle and abandon the scan.
REQ-019 After the idx=TSV_W-1 cycle, the block SHALL enter RUN with cfg_done high for exactly that first RUN cycle. A scan lasts exactly TSV_W cycles.
REQ-020 The stored shift sequence SHALL be non-decreasing in bit index, and every bit i SHALL map to a healthy TSV i+s_i.
REQ-021 ctrl_flags SHALL present the one-hot stored shifts only in RUN and SHALL be all-zero in IDLE, SCAN and FAIL.
REQ-022 in_ready SHALL equal (state==RUN). There is no backpressure in RUN.
REQ-023 On in_valid&&in_ready, the block SHALL update tsv_out on the next edge: tsv_out[i+s_i] = data_in[i] for every i, and every TSV not mapped to a bit is driven 0. tsv_valid SHALL be high for that one cycle.
REQ-024 Without an accepted transfer, tsv_out SHALL hold its last value (no toggling, so that crosstalk coding is preserved) and tsv_valid SHALL be 0.
REQ-025 in_valid outside RUN SHALL be ignored.
REQ-026 Leaving RUN through cfg_start SHALL leave tsv_out holding its value.
REQ-027 cfg_fail SHALL be 1 exactly while in FAIL.
REQ-028 Latency SHALL be 1 cycle from an accepted data_in to tsv_out.

Reset
REQ-029 rst_n low SHALL immediately force the following, regardless of state, including mid-SCAN:
  - state = IDLE;
  - tsv_out = 0, tsv_valid = 0, in_ready = 0;
  - ctrl_flags = 0, cfg_done = 0, cfg_fail = 0;
  - all stored shifts and scan counters cleared.
REQ-030 After reset, the block SHALL require a cfg_start before any data is accepted.

Verification
REQ-031 fault_map=0, cfg_start -> cfg_done 9 cycles later, every ctrl_flags field = 3'b001; data_in=7'h55 -> next cycle tsv_out=9'h055, tsv_valid=1.
REQ-032 fault_map=9'h008 (TSV3 faulty) -> fields 0-2 = 3'b001, fields 3-6 = 3'b010; data_in=7'h7F -> tsv_out=9'h0F7.
REQ-033 fault_map=9'h101 (TSV0 and TSV8 faulty) -> RUN reached (TSV8 ignored), all fields 3'b010; data_in=7'h01 -> tsv_out=9'h002.
REQ-034 fault_map=9'h007 -> cfg_fail=1 after the idx=2 cycle, cfg_done never pulses, in_ready=0, ctrl_flags=0; then cfg_start with fault_map=0 -> cfg_fail=0 and RUN after 9 cycles.
REQ-035 In RUN, in_valid low for 5 cycles -> tsv_out unchanged and tsv_valid=0 throughout; cfg_start issued during SCAN -> ignored and scan length unchanged.
REQ-036 rst_n asserted at scan idx=4 -> all outputs 0 immediately; after release, data_in with in_valid=1 -> in_ready=0 and tsv_out stays 0.
